// File: rtl/prra_arbiter.sv
// prra_arbiter: sequential round-robin arbiter with grant locking.
//
// Holds a priority pointer. Once a requester is granted, the grant stays
// locked on it for a whole multi-beat transfer. It is released on the last
// accepted beat (accept & last[g]) or when the requester withdraws its
// request. After a release the next winner is granted on the following
// cycle, with no idle bubble.
//
// Parameters:
//   WIDTH        number of requesters (>=2)
//   LOG2_WIDTH   width of the pointer and grant_index
//   STATE_OFFSET reset value of the pointer; the first search starts one above it
//   MAX_HOLD     maximum grant duration in cycles (timeout build only)
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   request      per-requester request (level)
//   last         per-requester "current beat is the final beat" flag
//   accept       downstream takes the granted requester's beat this cycle
//   grant_valid  a grant is active
//   grant        one-hot grant; zero when idle
//   grant_index  binary index of the granted requester; holds its value when idle
//   timeout      one-cycle pulse when a grant was force-released
//
// Optional feature: define PRRA_ARBITER_TIMEOUT_EN to add a hold counter.
// The counter force-releases a grant after MAX_HOLD cycles. Without the
// define there is no counter and timeout is tied to 0.
module prra_arbiter #(
  parameter int WIDTH        = 4,
  parameter int LOG2_WIDTH   = $clog2(WIDTH),
  parameter int STATE_OFFSET = 0,
  parameter int MAX_HOLD     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      request,
  input  logic [WIDTH-1:0]      last,
  input  logic                  accept,
  output logic                  grant_valid,
  output logic [WIDTH-1:0]      grant,
  output logic [LOG2_WIDTH-1:0] grant_index,
  output logic                  timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state_q, state_d;
  logic [LOG2_WIDTH-1:0] ptr_q, ptr_d;
  logic [LOG2_WIDTH-1:0] idx_d;
  logic [WIDTH-1:0]      grant_d;
  logic                  valid_d;
  logic                  done, rel, force_rel;
  logic [WIDTH-1:0]      cand;
  logic [LOG2_WIDTH-1:0] win;

`ifdef PRRA_ARBITER_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              to_q, to_d;
`endif

  // First set bit of req, scanning upward from p+1 with wrap-around.
  // The requester at p itself has the lowest priority. The loop runs from
  // the far end down, so the nearest hit is the one left in w.
  function automatic logic [LOG2_WIDTH-1:0] rr_pick(
    input logic [WIDTH-1:0]      req,
    input logic [LOG2_WIDTH-1:0] p
  );
    logic [LOG2_WIDTH-1:0] w;
    int                    l;
    w = p;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      l = (int'(p) + 1 + k) % WIDTH;
      if (req[l]) w = LOG2_WIDTH'(l);
    end
    return w;
  endfunction

  always_comb begin
    done = accept & last[grant_index];
    rel  = done | ~request[grant_index];
    // After a completed packet, g is still a candidate, but at the lowest
    // priority. After a withdrawal its request bit is already 0. In both
    // cases the raw request vector is the candidate set.
    cand      = request;
    force_rel = 1'b0;
`ifdef PRRA_ARBITER_TIMEOUT_EN
    force_rel = ~rel && (hold_q == HOLD_W'(MAX_HOLD - 1));
    if (force_rel) cand[grant_index] = 1'b0;
`endif
    win = rr_pick(cand, (state_q == GRANT) ? grant_index : ptr_q);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = grant_index;
    grant_d = grant;
    valid_d = grant_valid;
`ifdef PRRA_ARBITER_TIMEOUT_EN
    hold_d  = hold_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|request) begin
          state_d      = GRANT;
          valid_d      = 1'b1;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          idx_d        = win;
          ptr_d        = win;
`ifdef PRRA_ARBITER_TIMEOUT_EN
          hold_d       = '0;
`endif
        end
      end
      GRANT: begin
        if (rel || force_rel) begin
          if (|cand) begin
            grant_d      = '0;
            grant_d[win] = 1'b1;
            idx_d        = win;
            ptr_d        = win;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            grant_d = '0;
          end
`ifdef PRRA_ARBITER_TIMEOUT_EN
          hold_d = '0;
          to_d   = force_rel;
`endif
        end else begin
`ifdef PRRA_ARBITER_TIMEOUT_EN
          hold_d = hold_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= LOG2_WIDTH'(STATE_OFFSET);
      grant_index <= LOG2_WIDTH'(STATE_OFFSET);
      grant       <= '0;
      grant_valid <= 1'b0;
`ifdef PRRA_ARBITER_TIMEOUT_EN
      hold_q      <= '0;
      to_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_index <= idx_d;
      grant       <= grant_d;
      grant_valid <= valid_d;
`ifdef PRRA_ARBITER_TIMEOUT_EN
      hold_q      <= hold_d;
      to_q        <= to_d;
`endif
    end
  end

`ifdef PRRA_ARBITER_TIMEOUT_EN
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_prra_arbiter.sv
module tb_prra_arbiter;

`ifdef PRRA_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] request = '0;
  logic [3:0] last = '0;
  logic       accept = 1'b0;
  logic       grant_valid;
  logic [3:0] grant;
  logic [1:0] grant_index;
  logic       timeout;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic       v;
    logic [1:0] idx;
    logic       to;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  prra_arbiter #(.WIDTH(4), .STATE_OFFSET(0), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .request(request), .last(last), .accept(accept),
    .grant_valid(grant_valid), .grant(grant), .grant_index(grant_index),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expect_push(input string tag, input logic ev, input logic [1:0] ei, input logic et);
    exp_t e;
    e.v = ev; e.idx = ei; e.to = et;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    exp_t       e;
    string      t;
    logic [3:0] one;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    one = e.v ? (4'b0001 << e.idx) : 4'b0000;
    chk({t, ".valid"}, 32'(grant_valid), 32'(e.v));
    chk({t, ".grant"}, 32'(grant), 32'(one));
    chk({t, ".index"}, 32'(grant_index), 32'(e.idx));
    chk({t, ".timeout"}, 32'(timeout), 32'(e.to));
  endtask

  // Drive one cycle of inputs and state what the registered outputs must
  // look like after the next rising edge.
  task automatic step(input string tag, input logic [3:0] rq, input logic [3:0] ls,
                      input logic ac, input logic ev, input logic [1:0] ei, input logic et);
    request = rq; last = ls; accept = ac;
    expect_push(tag, ev, ei, et);
    @(posedge clk); #1;
    check_out();
  endtask

  initial begin
    // reset state
    #12;
    expect_push("reset", 1'b0, 2'd0, 1'b0);
    check_out();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // all request, single-beat packets: rotation with no gaps
    step("rot0", 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b0);
    step("rot1", 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b0);
    step("rot2", 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b0);
    step("rot3", 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b0);
    step("rot4", 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b0);
    step("drop", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0);

    // multi-beat packet on requester 2, then re-grant, then drop
    step("mb0", 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0);
    step("mb1", 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0);
    step("mb2", 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0);
    step("mb3", 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0);
    // with a 4-cycle hold limit, the grant is force-released here
    step("mb4", 4'b0100, 4'b0000, 1'b1, !TO_EN, 2'd2, TO_EN);
    step("mb5", 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0);
    step("mblast", 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0);
    step("mbdrop", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0);
    step("idleacc", 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd2, 1'b0);

    // lock on 1 while others come and go
    step("lk0", 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0);
    step("lk1", 4'b1011, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0);
    step("lk2", 4'b1011, 4'b1111, 1'b0, 1'b1, 2'd1, 1'b0);
    step("lkrel", 4'b1001, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b0);

    // sole requester 3 re-granted via wrap, then wrap to 0
    step("wrap3", 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0);
    step("wrap0", 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0);
    step("idle0", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    // asynchronous reset mid-grant
    step("pre_rst", 4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b0);
    rst_n = 1'b0;
    #2;
    expect_push("async_rst", 1'b0, 2'd0, 1'b0);
    check_out();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("post_rst", 4'b1111, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0);
    step("idle1", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0);

    // move the pointer to 3, then run the hold-limit case with request 1001
    step("to_p3", 4'b1000, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b0);
    step("to_idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b0);
    step("toA", 4'b1001, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0);
    step("toB", 4'b1001, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0);
    step("toC", 4'b1001, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0);
    step("toD", 4'b1001, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0);
    step("toE", 4'b1001, 4'b0000, 1'b0, 1'b1, TO_EN ? 2'd3 : 2'd0, TO_EN);
    step("toF", 4'b1001, 4'b0000, 1'b0, 1'b1, TO_EN ? 2'd3 : 2'd0, 1'b0);
    step("toend", 4'b0000, 4'b0000, 1'b0, 1'b0, TO_EN ? 2'd3 : 2'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
